neuron_mac: RTL and testbench
=============================

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter N_INPUTS, default 2: number of input/weight beats per neuron evaluation, legal range 1..16.
REQ-002 SHALL have parameter DW, default 8: data width of x, w, bias and z, all signed Q4.4.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: an x/w beat is offered.
REQ-006 SHALL have port in_ready, output, 1: the block accepts a beat.
REQ-007 SHALL have port x_data, input, DW signed: activation input.
REQ-008 SHALL have port w_data, input, DW signed: weight.
REQ-009 SHALL have port bias, input, DW signed: bias, sampled in FINAL.
REQ-010 SHALL have port z_valid, output, 1: z_value holds a result.
REQ-011 SHALL have port z_ready, input, 1: downstream activation stage accepts z.
REQ-012 SHALL have port z_value, output, DW signed: weighted sum in Q4.4; bits [7:4] form the activation-LUT address and bits [3:0] the interpolation remainder.
REQ-013 SHALL have port z_ovf, output, 1: sticky per result; set when the result exceeded the Q4.4 range.

Function
REQ-014 SHALL implement FSM states ACCUM, FINAL and OUT.
REQ-015 A beat SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready=1 only in ACCUM.
REQ-017 On each accepted beat, SHALL add the full-precision product x_data*w_data (16-bit, Q8.8) to a signed accumulator of 16+clog2(N_INPUTS)+1 bits.
REQ-018 On each accepted beat, SHALL increment the beat counter.
REQ-019 When the accepted beat is beat N_INPUTS, SHALL move ACCUM->FINAL and clear the counter.
REQ-020 In FINAL (one cycle), SHALL compute acc + (sign-extended bias << 4).
REQ-021 In FINAL, SHALL arithmetic-shift the sum right 4 (truncate toward -inf).
REQ-022 In FINAL, SHALL reduce the shifted sum to DW bits per REQ-030/REQ-031, register it into z_value and z_ovf, clear the accumulator, and move to OUT.
REQ-023 Latency: last beat accepted in cycle k -> z_valid=1 in cycle k+2.
REQ-024 In OUT, SHALL hold z_valid=1 and keep z_value and z_ovf stable until z_ready=1.
REQ-025 On the cycle with z_valid=1 and z_ready=1, SHALL return to ACCUM with z_valid=0 on the next cycle; next-frame beats are accepted no earlier than that cycle.
REQ-026 in_valid SHALL be ignored outside ACCUM, and x_data/w_data SHALL be don't-care when no beat is accepted.
REQ-027 With N_INPUTS=1, SHALL go to FINAL after every single accepted beat.

Reset
REQ-028 While rst_n=0, regardless of clock, SHALL force state=ACCUM, accumulator=0, counter=0, z_valid=0, z_value=0x00, z_ovf=0; in_ready SHALL be 1 from the first clk edge after rst_n rises.
REQ-029 Reset asserted mid-frame or in OUT SHALL discard the partial sum or pending result; no z_valid SHALL follow for that frame.

Configuration
REQ-030 With macro NEURON_MAC_SAT_EN defined, the REQ-022 reduction SHALL clamp values >127 to 0x7F and values <-128 to 0x80, setting z_ovf=1 when clamped.
REQ-031 Without NEURON_MAC_SAT_EN, the REQ-022 reduction SHALL take the low DW bits (two's-complement wrap), still setting z_ovf=1 when the value was out of range.

Structure
REQ-032 Package neuron_pkg SHALL hold the Q4.4 constants (DW=8, FRAC=4, QMAX=0x7F, QMIN=0x80) and the FSM state enum.
REQ-033 Shift, range check and saturation/wrap SHALL live in combinational sub-module neuron_mac_reduce (input: accumulator + aligned bias; outputs: z, ovf).
REQ-034 FSM, counter and accumulator SHALL live in neuron_mac.

Verification
REQ-035 N_INPUTS=2; beats (0x10,0x10),(0x10,0x10); bias=0xF0 -> z_value=0x10, z_ovf=0, z_valid exactly 2 cycles after the last beat.
REQ-036 SAT_EN; beats (0x7F,0x7F) x2; bias=0 -> z_value=0x7F, z_ovf=1. Same stimulus without SAT_EN -> z_value=0xE0, z_ovf=1.
REQ-037 SAT_EN; beats (0x80,0x7F) x2; bias=0x00 -> z_value=0x80, z_ovf=1. Beats (0xF8,0x10),(0x00,0x00); bias=0 -> z_value=0xF8, confirming truncation of -0.5.
REQ-038 Backpressure: hold z_ready=0 for 3 cycles with in_valid=1 -> z_value stable, in_ready=0, no beat consumed; z_ready=1 -> handshake completes and in_ready=1 on the next cycle.
REQ-039 Reset mid-frame: assert rst_n=0 after beat 1 of 2 -> z_valid stays 0. Next frame (0x20,0x10),(0x00,0x00), bias=0 -> z_value=0x20, no residue from the aborted frame.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared Q4.4 constants and FSM state encoding for the neuron MAC block.
package neuron_pkg;

  localparam int Q_DW = 8;
  localparam int FRAC = 4;
  localparam logic [7:0] QMAX = 8'h7F;
  localparam logic [7:0] QMIN = 8'h80;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FINAL = 2'd1,
    OUT   = 2'd2
  } state_e;

endpackage

// File: rtl/neuron_mac_reduce.sv
// Converts the Q8.8 accumulator plus aligned bias back to Q4.4 with an overflow flag.
// NEURON_MAC_SAT_EN selects clamping instead of two's-complement wrap.
module neuron_mac_reduce #(
  parameter int DW = 8,
  parameter int AW = 18
) (
  input  logic signed [AW-1:0] acc_i,
  input  logic signed [AW-1:0] bias_i,
  output logic        [DW-1:0] z_o,
  output logic                 ovf_o
);
  import neuron_pkg::*;

  logic signed [AW-1:0] sum_s;
  logic signed [AW-1:0] shifted_s;
  logic        [AW-DW:0] hi_s;

  // A value fits DW signed bits exactly when every bit from the sign position up agrees.
  always_comb begin
    sum_s     = acc_i + bias_i;
    shifted_s = sum_s >>> FRAC;
    hi_s      = shifted_s[AW-1:DW-1];
    ovf_o     = !((&hi_s) || !(|hi_s));
`ifdef NEURON_MAC_SAT_EN
    if (ovf_o) begin
      z_o = shifted_s[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      z_o = shifted_s[DW-1:0];
    end
`else
    z_o = shifted_s[DW-1:0];
`endif
  end

endmodule

// File: rtl/neuron_mac.sv
// Streaming multiply-accumulate neuron: N_INPUTS x/w beats, bias, Q4.4 result handshake.
// Define NEURON_MAC_SAT_EN to saturate the result instead of wrapping.
module neuron_mac #(
  parameter int N_INPUTS = 2,
  parameter int DW       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_data,
  input  logic signed [DW-1:0] w_data,
  input  logic signed [DW-1:0] bias,
  output logic                 z_valid,
  input  logic                 z_ready,
  output logic signed [DW-1:0] z_value,
  output logic                 z_ovf
);
  import neuron_pkg::*;

  localparam int AW = 2*DW + $clog2(N_INPUTS) + 1;
  localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);

  state_e               state_q, state_d;
  logic        [CW-1:0] cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic        [DW-1:0] z_value_q, z_value_d;
  logic                 z_ovf_q, z_ovf_d;
  logic                 z_valid_q, z_valid_d;
  logic                 in_ready_q, in_ready_d;

  logic signed [2*DW-1:0] prod_s;
  logic signed [AW-1:0]   prod_ext_s;
  logic signed [AW-1:0]   bias_al_s;
  logic        [DW-1:0]   red_z_s;
  logic                   red_ovf_s;

  assign prod_s     = x_data * w_data;
  assign prod_ext_s = {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s};
  assign bias_al_s  = {{(AW-DW-FRAC){bias[DW-1]}}, bias, {FRAC{1'b0}}};

  neuron_mac_reduce #(
    .DW (DW),
    .AW (AW)
  ) u_reduce (
    .acc_i  (acc_q),
    .bias_i (bias_al_s),
    .z_o    (red_z_s),
    .ovf_o  (red_ovf_s)
  );

  // Next-state logic; handshake outputs are derived from the next state so they come straight from flops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    z_value_d = z_value_q;
    z_ovf_d   = z_ovf_q;
    case (state_q)
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          acc_d = acc_q + prod_ext_s;
          if (cnt_q == LAST) begin
            cnt_d   = {CW{1'b0}};
            state_d = FINAL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          acc_d = acc_q;
        end
      end
      FINAL: begin
        z_value_d = red_z_s;
        z_ovf_d   = red_ovf_s;
        acc_d     = {AW{1'b0}};
        state_d   = OUT;
      end
      OUT: begin
        if (z_ready) begin
          state_d = ACCUM;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = ACCUM;
        cnt_d   = {CW{1'b0}};
        acc_d   = {AW{1'b0}};
      end
    endcase
    z_valid_d  = (state_d == OUT);
    in_ready_d = (state_d == ACCUM);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      cnt_q      <= {CW{1'b0}};
      acc_q      <= {AW{1'b0}};
      z_value_q  <= {DW{1'b0}};
      z_ovf_q    <= 1'b0;
      z_valid_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      z_value_q  <= z_value_d;
      z_ovf_q    <= z_ovf_d;
      z_valid_q  <= z_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign z_valid  = z_valid_q;
  assign z_value  = z_value_q;
  assign z_ovf    = z_ovf_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: directed frames plus random traffic against a frame-level model.
module tb_neuron_mac;
  localparam int N = 2;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x_data;
  logic signed [7:0] w_data;
  logic signed [7:0] bias;
  logic              z_valid;
  logic              z_ready;
  logic        [7:0] z_value;
  logic              z_ovf;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int         m_phase = 0;   // 0 collecting beats, 1 result being formed, 2 result presented
  int         m_beats = 0;
  int         m_sum = 0;
  int         m_results = 0;
  logic [7:0] m_z = 8'h00;
  logic       m_ovf = 1'b0;
  bit         post_rst = 1'b1;

  neuron_mac #(.N_INPUTS(N), .DW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_data   (x_data),
    .w_data   (w_data),
    .bias     (bias),
    .z_valid  (z_valid),
    .z_ready  (z_ready),
    .z_value  (z_value),
    .z_ovf    (z_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Result of a frame: floor((sum_of_products + 16*bias) / 16), then fit into 8 bits.
  function automatic logic [8:0] model_result(input int s, input int b);
    int v, q;
    logic o;
    logic [7:0] z;
    v = s + b * 16;
    q = v / 16;
    if (v < 0 && (v % 16) != 0) q = q - 1;
    o = (q > 127) || (q < -128);
`ifdef NEURON_MAC_SAT_EN
    if (q > 127) z = 8'h7F;
    else if (q < -128) z = 8'h80;
    else z = q[7:0];
`else
    z = q[7:0];
`endif
    return {o, z};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_z_valid", z_valid, 1'b0);
      chk("rst_z_value", z_value, 8'h00);
      chk("rst_z_ovf", z_ovf, 1'b0);
      m_phase  = 0;
      m_beats  = 0;
      m_sum    = 0;
      post_rst = 1'b1;
    end else begin
      if (!post_rst) chk("in_ready", in_ready, (m_phase == 0));
      chk("z_valid", z_valid, (m_phase == 2));
      if (m_phase == 2) begin
        chk("z_value", z_value, m_z);
        chk("z_ovf", z_ovf, m_ovf);
      end
      case (m_phase)
        0: if (in_valid && !post_rst) begin
             m_sum = m_sum + int'(x_data) * int'(w_data);
             m_beats++;
             if (m_beats == N) begin
               m_beats = 0;
               m_phase = 1;
             end
           end
        1: begin
             {m_ovf, m_z} = model_result(m_sum, int'(bias));
             m_sum = 0;
             m_results++;
             m_phase = 2;
           end
        default: if (z_ready) m_phase = 0;
      endcase
      post_rst = 1'b0;
    end
  end

  task automatic send_beat(input logic [7:0] x, input logic [7:0] w);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    x_data = x;
    w_data = w;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("beat_accepted", done, 1'b1);
  endtask

  task automatic wait_zvalid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!z_valid && n < 20);
  endtask

  task automatic run_frame(input logic [7:0] x0, input logic [7:0] w0,
                           input logic [7:0] x1, input logic [7:0] w1,
                           input logic [7:0] b, input logic [7:0] ez,
                           input logic eo, input string nm);
    int n;
    bias = b;
    z_ready = 1'b1;
    send_beat(x0, w0);
    send_beat(x1, w1);
    wait_zvalid(n);
    chk({nm, "_latency"}, n, 2);
    chk({nm, "_z"}, z_value, ez);
    chk({nm, "_ovf"}, z_ovf, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [8:0] r;
    rst_n = 1'b0; in_valid = 1'b0; z_ready = 1'b0;
    x_data = 8'sh00; w_data = 8'sh00; bias = 8'sh00;

    // model pins
    r = model_result(512, -16);   chk("pin_basic", r, 9'h010);
    r = model_result(-128, 0);    chk("pin_trunc", r, 9'h0F8);
    r = model_result(-1, 0);      chk("pin_floor", r, 9'h0FF);
`ifdef NEURON_MAC_SAT_EN
    r = model_result(32258, 0);   chk("pin_ovf", r, 9'h17F);
`else
    r = model_result(32258, 0);   chk("pin_ovf", r, 9'h1E0);
`endif

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    run_frame(8'h10, 8'h10, 8'h10, 8'h10, 8'hF0, 8'h10, 1'b0, "basic");
`ifdef NEURON_MAC_SAT_EN
    run_frame(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h7F, 1'b1, "pos_ovf");
    run_frame(8'h80, 8'h7F, 8'h80, 8'h7F, 8'h00, 8'h80, 1'b1, "neg_ovf");
    run_frame(8'h10, 8'h10, 8'h00, 8'h00, 8'h70, 8'h7F, 1'b1, "edge128");
`else
    run_frame(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'hE0, 1'b1, "pos_ovf");
    run_frame(8'h80, 8'h7F, 8'h80, 8'h7F, 8'h00, 8'h10, 1'b1, "neg_ovf");
    run_frame(8'h10, 8'h10, 8'h00, 8'h00, 8'h70, 8'h80, 1'b1, "edge128");
`endif
    run_frame(8'hF8, 8'h10, 8'h00, 8'h00, 8'h00, 8'hF8, 1'b0, "trunc");
    run_frame(8'h10, 8'h10, 8'h00, 8'h00, 8'h6F, 8'h7F, 1'b0, "edge127");

    // backpressure: result held while downstream stalls and beats are offered
    bias = 8'sh00;
    z_ready = 1'b0;
    send_beat(8'h30, 8'h10);
    send_beat(8'h10, 8'h20);
    wait_zvalid(n);
    chk("bp_z", z_value, 8'h50);
    @(posedge clk);
    #1;
    in_valid = 1'b1; x_data = 8'sh7F; w_data = 8'sh7F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_z", z_value, 8'h50);
      chk("bp_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    z_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_at_hs", z_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", in_ready, 1'b1);
    chk("bp_valid_after", z_valid, 1'b0);
    @(posedge clk);
    #1;

    // reset mid-frame discards the partial sum
    send_beat(8'h7F, 8'h7F);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_zvalid", z_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    run_frame(8'h20, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 1'b0, "resid");

    // random traffic with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      x_data   = 8'($urandom);
      w_data   = 8'($urandom);
      bias     = 8'($urandom);
      z_ready  = ($urandom_range(0, 2) != 0);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    z_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("random_results_seen", (m_results > 100), 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
